// File: rtl/ps2_pkg.sv
// PS/2 keyboard decoder shared definitions.
// Holds the set-2 prefix/response bytes, the frame FSM state type and the
// bit positions inside the 11-bit key event word.
package ps2_pkg;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_E1 = 8'hE1;
    localparam logic [7:0] CODE_AA = 8'hAA;
    localparam logic [7:0] CODE_FA = 8'hFA;
    localparam logic [7:0] CODE_EE = 8'hEE;
    localparam logic [7:0] CODE_FE = 8'hFE;
    localparam logic [7:0] CODE_00 = 8'h00;
    localparam logic [7:0] CODE_FF = 8'hFF;
    localparam logic [7:0] CODE_FC = 8'hFC;
    localparam logic [7:0] CODE_FD = 8'hFD;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;
    localparam int KEY_CODE_HI = 7;

    // Device responses and error codes that never form a key event.
    function automatic logic is_response(input logic [7:0] b);
        logic r;
        r = 1'b0;
        case (b)
            CODE_00, CODE_AA, CODE_EE, CODE_FA,
            CODE_FC, CODE_FD, CODE_FE, CODE_FF: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes both lines, glitch-filters the clock,
// deserializes 11-bit frames and discards stalled partial frames.
// Ports: clk_sys/reset (async, active-high); ps2_clk/ps2_data raw lines;
// rx_byte/byte_valid one-cycle received byte; frame_err one-cycle error.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          clk_meta;
    logic          clk_sync;
    logic          data_meta;
    logic          data_sync;
    logic          clk_filt;
    logic          clk_prev;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    frame_state_t  state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tcnt;

    // Lines idle high, so everything presets to 1.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_filt  <= 1'b1;
            clk_prev  <= 1'b1;
            flt_cnt   <= '0;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
            clk_prev  <= clk_filt;
            // Filtered level flips only after FILTER_LEN
            // consecutive samples at the new level.
            if (clk_sync == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_prev & ~clk_filt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || fall) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            if (state != IDLE && !fall &&
                tcnt == TW'(TIMEOUT - 1)) begin
                state     <= IDLE;
                shreg     <= '0;
                frame_err <= 1'b1;
            end else if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg  <= {data_sync, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= data_sync;
                        state   <= STOP;
                    end
                    STOP: begin
                        // Odd parity over data plus parity bit.
                        if (data_sync && (^{shreg, par_bit})) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: resolves E0/F0/E1 prefixes into the toggle-format
// key word. Ports: clk_sys, reset (async, active-high), ps2_clk, ps2_data,
// ps2_key {toggle, pressed, extended, code}, frame_err one-cycle pulse.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       ext;
    logic       brk;
    logic [2:0] skip;

    ps2_rx_frame #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_rx (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ps2_key <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            skip    <= '0;
        end else if (byte_valid) begin
            priority case (1'b1)
                (skip != 3'd0): begin
                    skip <= skip - 1'b1;
                end
                // Pause has no break code; swallow the
                // remaining seven bytes of its sequence.
                (rx_byte == CODE_E1): begin
                    skip <= 3'd7;
                    ext  <= 1'b0;
                    brk  <= 1'b0;
                end
                (rx_byte == CODE_E0): begin
                    ext <= 1'b1;
                end
                (rx_byte == CODE_F0): begin
                    brk <= 1'b1;
                end
                is_response(rx_byte): begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
                default: begin
                    ps2_key[KEY_TOGGLE]      <= ~ps2_key[KEY_TOGGLE];
                    ps2_key[KEY_PRESSED]     <= ~brk;
                    ps2_key[KEY_EXT]         <= ext;
                    ps2_key[KEY_CODE_HI:0]   <= rx_byte;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames push expected
// key words; a monitor compares them on every change of ps2_key.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 12000;
    localparam int HALF       = 20;
    localparam int LAT        = 12;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int          cyc      = 0;
    int          tests    = 0;
    int          fails    = 0;
    int          err_seen = 0;
    int          exp_err  = 0;
    int          stop_cyc = 0;
    logic        tog      = 1'b0;
    logic [10:0] prev_key = '0;
    logic [10:0] exp_q[$];

    ps2_key_decoder #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Monitor: every change of ps2_key outside reset is one event.
    always @(negedge clk_sys) begin
        logic [10:0] e;
        if (frame_err === 1'b1) err_seen++;
        if (reset === 1'b0 && ps2_key !== prev_key) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event got %h required none",
                         ps2_key);
            end else begin
                e = exp_q.pop_front();
                if (ps2_key !== e) begin
                    fails++;
                    $display("FAIL event got %h required %h",
                             ps2_key, e);
                end
                tests++;
                if (cyc - stop_cyc != LAT) begin
                    fails++;
                    $display("FAIL latency got %0d required %0d",
                             cyc - stop_cyc, LAT);
                end
            end
        end
        prev_key = ps2_key;
    end

    initial begin
        repeat (90000) @(posedge clk_sys);
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic void expect_key(input logic p, input logic x,
                                       input logic [7:0] c);
        tog = ~tog;
        exp_q.push_back({tog, p, x, c});
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // One bit: data set while clock high, then clock low, then high.
    task automatic put_bit(input logic b, input bit glitch,
                           input bit is_stop);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(11);
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 14);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit flip,
                        input bit glitch);
        logic [10:0] f;
        f = {1'b1, ~(^b) ^ flip, b, 1'b0};
        for (int i = 0; i < 11; i++) put_bit(f[i], glitch, i == 10);
        wait_cyc(2 * HALF);
    endtask

    task automatic partial(input int nbits);
        put_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) put_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_err(input string name);
        tests++;
        if (err_seen != exp_err) begin
            fails++;
            $display("FAIL %s frame_err pulses got %0d required %0d",
                     name, err_seen, exp_err);
        end
    endtask

    task automatic check_empty(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s pending events got %0d required 0",
                     name, exp_q.size());
        end
    endtask

    initial begin
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(5);
        tests++;
        if (ps2_key !== 11'h000 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got %h/%b required 000/0",
                     ps2_key, frame_err);
        end

        expect_key(1'b1, 1'b0, 8'h1C);
        send(8'h1C, 1'b0, 1'b0);
        check_err("make_1c");

        expect_key(1'b0, 1'b0, 8'h1C);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h1C, 1'b0, 1'b0);

        expect_key(1'b0, 1'b1, 8'h75);
        send(8'hE0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h75, 1'b0, 1'b0);

        expect_key(1'b1, 1'b0, 8'h29);
        send(8'h29, 1'b0, 1'b0);
        check_err("prefixes");

        exp_err++;
        send(8'h29, 1'b1, 1'b0);
        check_err("bad_parity");
        expect_key(1'b1, 1'b0, 8'h29);
        send(8'h29, 1'b0, 1'b0);

        send(8'hE1, 1'b0, 1'b0);
        send(8'h14, 1'b0, 1'b0);
        send(8'h77, 1'b0, 1'b0);
        send(8'hE1, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h14, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h77, 1'b0, 1'b0);
        expect_key(1'b1, 1'b0, 8'h16);
        send(8'h16, 1'b0, 1'b0);
        check_empty("pause");

        partial(4);
        wait_cyc(TIMEOUT + 10);
        exp_err++;
        check_err("timeout");
        expect_key(1'b1, 1'b0, 8'h45);
        send(8'h45, 1'b0, 1'b0);

        expect_key(1'b1, 1'b0, 8'h5A);
        send(8'h5A, 1'b0, 1'b1);
        check_err("glitch");

        expect_key(1'b1, 1'b0, 8'h1C);
        send(8'hE0, 1'b0, 1'b0);
        send(8'hFA, 1'b0, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        check_empty("response");

        partial(3);
        @(negedge clk_sys);
        #2 reset = 1'b1;
        tog = 1'b0;
        #1;
        tests++;
        if (ps2_key !== 11'h000 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got %h/%b required 000/0",
                     ps2_key, frame_err);
        end
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(4);

        expect_key(1'b1, 1'b0, 8'h1C);
        send(8'h1C, 1'b0, 1'b0);
        check_err("after_reset");
        check_empty("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
